// File: rtl/bmap144_pkg.sv
// rtl/bmap144_pkg.sv - shared slot-numbering types and constants for the 144-entry bitmap allocator
package bmap144_pkg;

    localparam int NSLOT = 144;
    localparam logic [7:0] NONE = 8'd255;

    typedef logic [7:0]   slot_idx_t;
    typedef logic [143:0] slot_map_t;

endpackage

// File: rtl/bmap144_alloc_dec144.sv
// rtl/bmap144_alloc_dec144.sv - index-to-one-hot decoder, all-zero for indices past the last slot
module dec144
    import bmap144_pkg::*;
(
    input  slot_idx_t idx_i,
    output slot_map_t mask_o
);

    // One comparator per slot; indices 144..255 match no slot and leave the mask empty.
    always_comb begin
        mask_o = '0;
        for (int i = 0; i < NSLOT; i++) begin
            mask_o[i] = (idx_i == slot_idx_t'(i));
        end
    end

endmodule

// File: rtl/bmap144_alloc.sv
// rtl/bmap144_alloc.sv - registered 144-slot bitmap allocator; BMAP144_NFREE_EN builds the free counter
module bmap144_alloc
    import bmap144_pkg::*;
#(
    parameter logic INIT_FREE = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       alloc_req_i,
    output logic       alloc_ack_o,
    output logic       alloc_fail_o,
    output logic [7:0] alloc_idx_o,
    input  logic       free_req_i,
    input  logic [7:0] free_idx_i,
    output logic       free_err_o,
    output logic [143:0] map_o,
    output logic [7:0] nfree_o
);

    slot_map_t map_q, map_d;
    slot_map_t free_mask, grant_mask;
    slot_idx_t search_idx;
    slot_idx_t alloc_idx_q, alloc_idx_d;
    logic      alloc_ack_q, alloc_fail_q, free_err_q;
    logic      grant, free_ok;

    // Lowest free slot of the pre-update map; scanning downward lets the lowest hit win.
    always_comb begin
        search_idx = NONE;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (map_q[i]) begin
                search_idx = slot_idx_t'(i);
            end
        end
    end

    dec144 u_free_dec (
        .idx_i  (free_idx_i),
        .mask_o (free_mask)
    );

    dec144 u_grant_dec (
        .idx_i  (search_idx),
        .mask_o (grant_mask)
    );

    // A free is legal only when it targets an existing, currently owned slot; the two
    // updates touch disjoint bits, so they can be merged into one next-state map.
    always_comb begin
        grant       = alloc_req_i && (search_idx != NONE);
        free_ok     = free_req_i && ((free_mask & ~map_q) != '0);
        map_d       = map_q;
        if (grant) begin
            map_d = map_d & ~grant_mask;
        end
        if (free_ok) begin
            map_d = map_d | free_mask;
        end
        alloc_idx_d = grant ? search_idx : NONE;
    end

    // Map and one-cycle response registers; reset drops any request in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            map_q        <= {NSLOT{INIT_FREE}};
            alloc_ack_q  <= 1'b0;
            alloc_fail_q <= 1'b0;
            free_err_q   <= 1'b0;
            alloc_idx_q  <= NONE;
        end else begin
            map_q        <= map_d;
            alloc_ack_q  <= grant;
            alloc_fail_q <= alloc_req_i && !grant;
            free_err_q   <= free_req_i && !free_ok;
            alloc_idx_q  <= alloc_idx_d;
        end
    end

    assign map_o        = map_q;
    assign alloc_ack_o  = alloc_ack_q;
    assign alloc_fail_o = alloc_fail_q;
    assign alloc_idx_o  = alloc_idx_q;
    assign free_err_o   = free_err_q;

`ifdef BMAP144_NFREE_EN
    slot_idx_t nfree_q, nfree_d;

    // Population count tracked incrementally; a grant and a legal free in one cycle cancel.
    always_comb begin
        nfree_d = nfree_q;
        if (free_ok && !grant) begin
            nfree_d = nfree_q + 8'd1;
        end else if (grant && !free_ok) begin
            nfree_d = nfree_q - 8'd1;
        end
    end

    // Free-slot counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            nfree_q <= INIT_FREE ? slot_idx_t'(NSLOT) : 8'd0;
        end else begin
            nfree_q <= nfree_d;
        end
    end

    assign nfree_o = nfree_q;
`else
    assign nfree_o = 8'd0;
`endif

endmodule

// File: tb/tb_bmap144_alloc.sv
// tb/tb_bmap144_alloc.sv - self-checking bench for bmap144_alloc against a slot-set reference model
module tb_bmap144_alloc;
    import bmap144_pkg::*;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         alloc_req_i = 1'b0;
    logic         free_req_i = 1'b0;
    logic [7:0]   free_idx_i = 8'd0;
    logic         alloc_ack_o, alloc_fail_o, free_err_o;
    logic [7:0]   alloc_idx_o, nfree_o;
    logic [143:0] map_o;

    int compared = 0;
    int mismatched = 0;

    logic [143:0] mdl;
    logic         exp_ack, exp_fail, exp_err;
    logic [7:0]   exp_idx, exp_nfree;

    bmap144_alloc dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .alloc_req_i  (alloc_req_i),
        .alloc_ack_o  (alloc_ack_o),
        .alloc_fail_o (alloc_fail_o),
        .alloc_idx_o  (alloc_idx_o),
        .free_req_i   (free_req_i),
        .free_idx_i   (free_idx_i),
        .free_err_o   (free_err_o),
        .map_o        (map_o),
        .nfree_o      (nfree_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [7:0] model_nfree();
`ifdef BMAP144_NFREE_EN
        return 8'($countones(mdl));
`else
        return 8'd0;
`endif
    endfunction

    task automatic step(input logic a, input logic f, input logic [7:0] fi);
        int low;
        alloc_req_i = a;
        free_req_i  = f;
        free_idx_i  = fi;
        @(posedge clk_i);
        #1;
        alloc_req_i = 1'b0;
        free_req_i  = 1'b0;
        low = -1;
        for (int i = 0; i < NSLOT; i++) begin
            if (mdl[i] && low < 0) low = i;
        end
        exp_ack  = a && (low >= 0);
        exp_fail = a && (low < 0);
        exp_idx  = exp_ack ? 8'(low) : NONE;
        exp_err  = 1'b0;
        if (f) begin
            if (int'(fi) >= NSLOT) exp_err = 1'b1;
            else if (mdl[fi]) exp_err = 1'b1;
        end
        if (exp_ack) mdl[low] = 1'b0;
        if (f && !exp_err) mdl[fi] = 1'b1;
        exp_nfree = model_nfree();
    endtask

    task automatic do_reset(input logic with_alloc);
        rst_i = 1'b1;
        alloc_req_i = with_alloc;
        free_req_i = with_alloc;
        free_idx_i = 8'd7;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        alloc_req_i = 1'b0;
        free_req_i = 1'b0;
        mdl = '1;
        exp_ack = 1'b0; exp_fail = 1'b0; exp_err = 1'b0; exp_idx = NONE;
        exp_nfree = model_nfree();
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        compared++;
        if (alloc_ack_o !== 1'b0 || alloc_fail_o !== 1'b0 || free_err_o !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_pulses: ack=%b fail=%b err=%b, required all 0", alloc_ack_o, alloc_fail_o, free_err_o);
        end
        compared++;
        if (alloc_idx_o !== 8'd255) begin
            mismatched++;
            $display("FAIL reset_idx: got %0d, required 255", alloc_idx_o);
        end
        compared++;
        if (map_o !== {144{1'b1}}) begin
            mismatched++;
            $display("FAIL reset_map: got %h, required all ones", map_o);
        end
        compared++;
        if (nfree_o !== exp_nfree) begin
            mismatched++;
            $display("FAIL reset_nfree: got %0d, required %0d", nfree_o, exp_nfree);
        end
    endtask

    task automatic test_three_allocs();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 8'd0);
            compared++;
            if (alloc_ack_o !== 1'b1 || alloc_idx_o !== 8'(i)) begin
                mismatched++;
                $display("FAIL alloc3_idx[%0d]: ack=%b idx=%0d, required ack=1 idx=%0d", i, alloc_ack_o, alloc_idx_o, i);
            end
            compared++;
            if (nfree_o !== exp_nfree) begin
                mismatched++;
                $display("FAIL alloc3_nfree[%0d]: got %0d, required %0d", i, nfree_o, exp_nfree);
            end
        end
        compared++;
        if (map_o[2:0] !== 3'b000) begin
            mismatched++;
            $display("FAIL alloc3_map: map[2:0]=%b, required 000", map_o[2:0]);
        end
    endtask

    task automatic test_simultaneous();
        step(1'b1, 1'b1, 8'd1);
        compared++;
        if (alloc_ack_o !== 1'b1 || alloc_idx_o !== 8'd3) begin
            mismatched++;
            $display("FAIL simul_idx: ack=%b idx=%0d, required ack=1 idx=3", alloc_ack_o, alloc_idx_o);
        end
        compared++;
        if (map_o[1] !== 1'b1 || map_o !== mdl) begin
            mismatched++;
            $display("FAIL simul_map: got %h, required %h", map_o, mdl);
        end
        compared++;
        if (nfree_o !== exp_nfree) begin
            mismatched++;
            $display("FAIL simul_nfree: got %0d, required %0d", nfree_o, exp_nfree);
        end
    endtask

    task automatic test_free_errors();
        logic [7:0] bad [2];
        bad[0] = 8'd1;
        bad[1] = 8'd200;
        for (int k = 0; k < 2; k++) begin
            step(1'b0, 1'b1, bad[k]);
            compared++;
            if (free_err_o !== 1'b1) begin
                mismatched++;
                $display("FAIL free_err[%0d]: got %b, required 1", bad[k], free_err_o);
            end
            compared++;
            if (map_o !== mdl || nfree_o !== exp_nfree) begin
                mismatched++;
                $display("FAIL free_err_state[%0d]: map=%h nfree=%0d, required map=%h nfree=%0d",
                         bad[k], map_o, nfree_o, mdl, exp_nfree);
            end
        end
        step(1'b0, 1'b0, 8'd0);
        compared++;
        if (free_err_o !== 1'b0 || alloc_ack_o !== 1'b0 || alloc_idx_o !== 8'd255) begin
            mismatched++;
            $display("FAIL idle_pulses: err=%b ack=%b idx=%0d, required 0 0 255", free_err_o, alloc_ack_o, alloc_idx_o);
        end
    endtask

    task automatic test_fill_and_refree();
        int bad_idx;
        do_reset(1'b0);
        bad_idx = 0;
        for (int i = 0; i < NSLOT; i++) begin
            step(1'b1, 1'b0, 8'd0);
            if (alloc_ack_o !== 1'b1 || alloc_idx_o !== 8'(i)) bad_idx++;
        end
        compared++;
        if (bad_idx != 0) begin
            mismatched++;
            $display("FAIL fill_sequence: %0d grants out of order, required 0", bad_idx);
        end
        compared++;
        if (nfree_o !== 8'd0 || map_o !== '0) begin
            mismatched++;
            $display("FAIL fill_full: nfree=%0d map=%h, required 0 and 0", nfree_o, map_o);
        end
        step(1'b1, 1'b0, 8'd0);
        compared++;
        if (alloc_fail_o !== 1'b1 || alloc_ack_o !== 1'b0 || alloc_idx_o !== 8'd255) begin
            mismatched++;
            $display("FAIL full_alloc: fail=%b ack=%b idx=%0d, required 1 0 255", alloc_fail_o, alloc_ack_o, alloc_idx_o);
        end
        step(1'b0, 1'b1, 8'd143);
        compared++;
        if (map_o[143] !== 1'b1 || free_err_o !== 1'b0) begin
            mismatched++;
            $display("FAIL refree_143: map[143]=%b err=%b, required 1 0", map_o[143], free_err_o);
        end
        step(1'b1, 1'b0, 8'd0);
        compared++;
        if (alloc_ack_o !== 1'b1 || alloc_idx_o !== 8'd143) begin
            mismatched++;
            $display("FAIL realloc_143: ack=%b idx=%0d, required 1 143", alloc_ack_o, alloc_idx_o);
        end
        do_reset(1'b1);
        compared++;
        if (alloc_ack_o !== 1'b0 || alloc_fail_o !== 1'b0 || free_err_o !== 1'b0 || map_o !== {144{1'b1}}) begin
            mismatched++;
            $display("FAIL reset_with_req: ack=%b fail=%b err=%b map=%h, required 0 0 0 all ones",
                     alloc_ack_o, alloc_fail_o, free_err_o, map_o);
        end
        compared++;
        if (nfree_o !== exp_nfree) begin
            mismatched++;
            $display("FAIL reset_with_req_nfree: got %0d, required %0d", nfree_o, exp_nfree);
        end
    endtask

    task automatic test_random();
        int errs;
        logic a, f;
        logic [7:0] fi;
        errs = 0;
        for (int n = 0; n < 600; n++) begin
            a  = ($urandom_range(0, 99) < 55);
            f  = ($urandom_range(0, 99) < 50);
            fi = 8'($urandom_range(0, 159));
            step(a, f, fi);
            compared++;
            if (alloc_ack_o !== exp_ack || alloc_fail_o !== exp_fail || alloc_idx_o !== exp_idx ||
                free_err_o !== exp_err || map_o !== mdl || nfree_o !== exp_nfree) begin
                mismatched++;
                errs++;
                if (errs <= 5)
                    $display("FAIL random[%0d]: ack=%b fail=%b idx=%0d err=%b nfree=%0d, required %b %b %0d %b %0d",
                             n, alloc_ack_o, alloc_fail_o, alloc_idx_o, free_err_o, nfree_o,
                             exp_ack, exp_fail, exp_idx, exp_err, exp_nfree);
            end
        end
    endtask

    initial begin
        test_reset();
        test_three_allocs();
        test_simultaneous();
        test_free_errors();
        test_fill_and_refree();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
